// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the fetch PC, issues single-outstanding reads to instruction memory,
// buffers up to two fetched words and feeds the IF/ID register, flushing on redirects.
module instruction_fetch_unit #(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      PC_STEP  = 1,
  parameter logic [WIDTH-1:0] NOP      = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] pr1_instruction,
  output logic [WIDTH-1:0] pr1_PC,
  output logic             pr1_enable_n
);

  localparam logic [1:0] DEPTH = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
  } entry_t;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] req_addr_q, req_addr_d;
  entry_t [1:0]     fifo_q, fifo_d;
  logic [1:0]       count_q, count_d;
  logic             pop, push, wr_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      fifo_q     <= '0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      fifo_q     <= fifo_d;
      count_q    <= count_d;
    end
  end

  // Next-state: request sequencing, FIFO push/pop and redirect flush
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    fifo_d     = fifo_q;
    count_d    = count_q;
    push       = 1'b0;
    pop        = ~stall & ~redirect_valid & (count_q != 2'd0);

    case (state_q)
      ST_IDLE: begin
        if (!redirect_valid && (count_q < DEPTH)) begin
          req_addr_d = fetch_pc_q;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (redirect_valid) begin
          state_d = imem_rvalid ? ST_IDLE : ST_DISCARD;
        end else if (imem_rvalid) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + WIDTH'(PC_STEP);
          state_d    = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (imem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Push lands behind whatever survives this cycle's pop
    wr_idx = (count_q == DEPTH) | ((count_q == 2'd1) & ~pop);
    if (pop) fifo_d[0] = fifo_q[1];
    if (push) begin
      fifo_d[wr_idx].instr = imem_rdata;
      fifo_d[wr_idx].pc    = req_addr_q;
    end
    count_d = count_q - 2'(pop) + 2'(push);

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      count_d    = 2'd0;
    end
  end

  assign imem_req  = (state_q != ST_IDLE);
  assign imem_addr = req_addr_q;

  // IF/ID feed: flush bubble on redirect, else FIFO head, else a NOP bubble
  always_comb begin
    pr1_instruction = NOP;
    pr1_PC          = fetch_pc_q;
    if (redirect_valid) begin
      pr1_PC = redirect_pc;
    end else if (count_q != 2'd0) begin
      pr1_instruction = fifo_q[0].instr;
      pr1_PC          = fifo_q[0].pc;
    end
  end

  assign pr1_enable_n = stall & ~redirect_valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, stall back-pressure, redirects,
// PC wrap (second instance with RESET_PC=FFFF) and reset during an outstanding request.
module tb_instruction_fetch_unit;

  localparam logic [15:0] NOP = 16'h0000;

  logic        clk;
  logic        reset, stall, redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        imem_req, imem_req_w;
  logic [15:0] imem_addr, imem_addr_w;
  logic [15:0] pr1_instruction, pr1_instruction_w;
  logic [15:0] pr1_PC, pr1_PC_w;
  logic        pr1_enable_n, pr1_enable_n_w;

  int n_checks;
  int n_fail;
  int lat;
  int wcnt;
  logic req_prev, rv_prev;

  instruction_fetch_unit u_dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pr1_instruction(pr1_instruction), .pr1_PC(pr1_PC), .pr1_enable_n(pr1_enable_n)
  );

  instruction_fetch_unit #(.RESET_PC(16'hFFFF)) u_dut_w (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pr1_instruction(pr1_instruction_w), .pr1_PC(pr1_PC_w), .pr1_enable_n(pr1_enable_n_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: memory model answers lat cycles after the request rises, data = 0x1000 + addr
  task automatic step(input logic rst, input logic st, input logic rd, input logic [15:0] rpc);
    req_prev = imem_req;
    rv_prev  = imem_rvalid;
    @(posedge clk);
    if (req_prev && rv_prev) wcnt = 0;
    else if (req_prev)       wcnt++;
    else                     wcnt = 0;
    @(negedge clk);
    imem_rvalid    = imem_req && (wcnt == lat);
    imem_rdata     = imem_rvalid ? (16'h1000 + imem_addr) : 16'hDEAD;
    reset          = rst;
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    step(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; lat = 0; wcnt = 0;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
    imem_rvalid = 1'b0; imem_rdata = 16'h0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_instr", pr1_instruction, NOP);
    chk("rst_pc", pr1_PC, 16'h0000);
    chk("rst_en", pr1_enable_n, 1'b0);
    chk("rst_pc_w", pr1_PC_w, 16'hFFFF);
    stall = 1'b1; #1;
    chk("rst_en_stall", pr1_enable_n, 1'b1);
    stall = 1'b0; reset = 1'b0; #1;
    chk("c0_req", imem_req, 1'b0);

    // Zero-wait streaming, and PC wrap on the FFFF instance
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0);
      chk("str_req", imem_req, 1'b1);
      chk("str_addr", imem_addr, 16'(k));
      chk("str_bubble", pr1_instruction, NOP);
      chk("wrap_addr", imem_addr_w, 16'(16'hFFFF + k));
      step(1'b0, 1'b0, 1'b0, 16'h0);
      chk("str_instr", pr1_instruction, 16'(16'h1000 + k));
      chk("str_pc", pr1_PC, 16'(k));
      chk("str_en", pr1_enable_n, 1'b0);
      chk("str_req_idle", imem_req, 1'b0);
      chk("wrap_pc", pr1_PC_w, 16'(16'hFFFF + k));
    end

    // Stall for 6 cycles: queue fills to two, requests stop
    stall = 1'b1; #1;
    chk("stl_en", pr1_enable_n, 1'b1);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("stl_req", imem_req, 1'b1);
    chk("stl_addr", imem_addr, 16'h0004);
    chk("stl_pc_hold", pr1_PC, 16'h0003);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0);
      chk("stl_full_noreq", imem_req, 1'b0);
      chk("stl_full_pc", pr1_PC, 16'h0003);
      chk("stl_full_instr", pr1_instruction, 16'h1003);
    end
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("rel_pc0", pr1_PC, 16'h0003);
    chk("rel_en", pr1_enable_n, 1'b0);
    chk("rel_req0", imem_req, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("rel_pc1", pr1_PC, 16'h0004);
    chk("rel_instr1", pr1_instruction, 16'h1004);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("rel_addr", imem_addr, 16'h0005);
    chk("rel_bubble", pr1_instruction, NOP);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("rel_pc2", pr1_PC, 16'h0005);

    // 3-cycle latency, redirect in the second wait cycle
    lat = 3;
    apply_reset();
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("dis_req", imem_req, 1'b1);
    step(1'b0, 1'b0, 1'b1, 16'h0040);
    chk("dis_flush_instr", pr1_instruction, NOP);
    chk("dis_flush_pc", pr1_PC, 16'h0040);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("dis_addr_hold", imem_addr, 16'h0000);
    chk("dis_req_hold", imem_req, 1'b1);
    chk("dis_fetch_pc", pr1_PC, 16'h0040);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("dis_rv_addr", imem_addr, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("dis_dropped", pr1_instruction, NOP);
    chk("dis_idle", imem_req, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("dis_new_addr", imem_addr, 16'h0040);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("dis_new_instr", pr1_instruction, 16'h1040);
    chk("dis_new_pc", pr1_PC, 16'h0040);

    // Redirect coinciding with rvalid, one entry queued, stall held
    lat = 0;
    apply_reset();
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("rr_head", pr1_instruction, 16'h1000);
    chk("rr_en_stall", pr1_enable_n, 1'b1);
    step(1'b0, 1'b1, 1'b1, 16'h0080);
    chk("rr_addr", imem_addr, 16'h0001);
    chk("rr_nop", pr1_instruction, NOP);
    chk("rr_en_flush", pr1_enable_n, 1'b0);
    chk("rr_pc", pr1_PC, 16'h0080);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("rr_empty", pr1_instruction, NOP);
    chk("rr_empty_pc", pr1_PC, 16'h0080);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("rr_next_addr", imem_addr, 16'h0080);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("rr_next_instr", pr1_instruction, 16'h1080);

    // Reset while BUSY, then a stray rvalid in IDLE
    lat = 3;
    apply_reset();
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("rb_busy", imem_req, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    apply_reset();
    chk("rb_req", imem_req, 1'b0);
    chk("rb_instr", pr1_instruction, NOP);
    chk("rb_pc", pr1_PC, 16'h0000);
    chk("rb_pc_w", pr1_PC_w, 16'hFFFF);
    imem_rvalid = 1'b1; imem_rdata = 16'h7777; #1;
    chk("rb_stray_instr", pr1_instruction, NOP);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("rb_after_req", imem_req, 1'b1);
    chk("rb_after_addr", imem_addr, 16'h0000);
    chk("rb_no_push", pr1_instruction, NOP);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
